parking_gate_arbiter: RTL and testbench

//  Shares the single barrier gate of the car park between an entry requester (password-verified

---
 rtl/parking_gate_arbiter.sv | 146 ++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// Single-gate arbiter for the car park: grants entry/exit one at a time, holds the barrier
// open until the car passes or a timeout fires, and tracks lot occupancy against CAPACITY.
module parking_gate_arbiter #(
    parameter int CAPACITY     = 8,
    parameter int CNT_W        = $clog2(CAPACITY + 1),
    parameter int OPEN_TIMEOUT = 16,
    parameter int CLOSE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_passed,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             timeout_err,
    output logic             busy
);

    localparam int TMR_W = $clog2(OPEN_TIMEOUT);
    localparam int CLS_W = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_TIMEOUT - 1);
    localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(CLOSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] OCC_MAX  = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {IDLE, WAIT_IN, WAIT_OUT, CLOSING} state_t;
    typedef enum logic {DIR_ENTRY, DIR_EXIT} dir_t;

    state_t           r_state,       w_state_nxt;
    logic [TMR_W-1:0] r_timer,       w_timer_nxt;
    logic [CLS_W-1:0] r_close_cnt,   w_close_cnt_nxt;
    logic [CNT_W-1:0] r_occ,         w_occ_nxt;
    logic             r_entry_grant, w_entry_grant_nxt;
    logic             r_exit_grant,  w_exit_grant_nxt;
    logic             r_gate_open,   w_gate_open_nxt;
    logic             r_timeout_err, w_timeout_err_nxt;
    dir_t             r_last_served, w_last_served_nxt;

    logic w_elig_in, w_elig_out, w_serve_in, w_serve_out;

    assign lot_full  = (r_occ == OCC_MAX);
    assign lot_empty = (r_occ == '0);
    assign busy      = (r_state != IDLE);

    // Eligibility keeps occupancy inside 0..CAPACITY, so the counter never needs saturation.
    assign w_elig_in   = entry_req & ~lot_full;
    assign w_elig_out  = exit_req & ~lot_empty;
    assign w_serve_in  = w_elig_in & (~w_elig_out | (r_last_served == DIR_EXIT));
    assign w_serve_out = w_elig_out & ~w_serve_in;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_state_nxt       = r_state;
        w_timer_nxt       = r_timer;
        w_close_cnt_nxt   = r_close_cnt;
        w_occ_nxt         = r_occ;
        w_entry_grant_nxt = 1'b0;
        w_exit_grant_nxt  = 1'b0;
        w_gate_open_nxt   = r_gate_open;
        w_timeout_err_nxt = 1'b0;
        w_last_served_nxt = r_last_served;

        case (r_state)
            IDLE: begin
                w_gate_open_nxt = 1'b0;
                if (w_serve_in) begin
                    w_state_nxt       = WAIT_IN;
                    w_entry_grant_nxt = 1'b1;
                    w_gate_open_nxt   = 1'b1;
                    w_timer_nxt       = '0;
                    w_last_served_nxt = DIR_ENTRY;
                end else if (w_serve_out) begin
                    w_state_nxt       = WAIT_OUT;
                    w_exit_grant_nxt  = 1'b1;
                    w_gate_open_nxt   = 1'b1;
                    w_timer_nxt       = '0;
                    w_last_served_nxt = DIR_EXIT;
                end
            end

            WAIT_IN, WAIT_OUT: begin
                // A passing car takes priority over a timeout landing on the same edge.
                if (car_passed) begin
                    w_occ_nxt       = (r_state == WAIT_IN) ? r_occ + CNT_W'(1) : r_occ - CNT_W'(1);
                    w_gate_open_nxt = 1'b0;
                    w_state_nxt     = CLOSING;
                    w_close_cnt_nxt = '0;
                end else if (r_timer == TMR_LAST) begin
                    w_timeout_err_nxt = 1'b1;
                    w_gate_open_nxt   = 1'b0;
                    w_state_nxt       = CLOSING;
                    w_close_cnt_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end

            CLOSING: begin
                w_gate_open_nxt = 1'b0;
                if (r_close_cnt == CLS_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_close_cnt_nxt = r_close_cnt + CLS_W'(1);
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_close_cnt   <= '0;
            r_occ         <= '0;
            r_entry_grant <= 1'b0;
            r_exit_grant  <= 1'b0;
            r_gate_open   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_last_served <= DIR_EXIT;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_close_cnt   <= w_close_cnt_nxt;
            r_occ         <= w_occ_nxt;
            r_entry_grant <= w_entry_grant_nxt;
            r_exit_grant  <= w_exit_grant_nxt;
            r_gate_open   <= w_gate_open_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_last_served <= w_last_served_nxt;
        end
    end

    assign entry_grant = r_entry_grant;
    assign exit_grant  = r_exit_grant;
    assign gate_open   = r_gate_open;
    assign occupancy   = r_occ;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: grant expectations are queued when a request is
// driven and checked (direction, occupancy, gate-open length) by a monitor when a grant appears.
module tb_parking_gate_arbiter;

    localparam int CAPACITY     = 8;
    localparam int CNT_W        = 4;
    localparam int OPEN_TIMEOUT = 16;
    localparam int CLOSE_CYCLES = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             entry_req = 1'b0;
    logic             exit_req = 1'b0;
    logic             car_passed = 1'b0;
    logic             entry_grant, exit_grant, gate_open;
    logic [CNT_W-1:0] occupancy;
    logic             lot_full, lot_empty, timeout_err, busy;

    parking_gate_arbiter #(
        .CAPACITY    (CAPACITY),
        .CNT_W       (CNT_W),
        .OPEN_TIMEOUT(OPEN_TIMEOUT),
        .CLOSE_CYCLES(CLOSE_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .car_passed (car_passed),
        .entry_grant(entry_grant),
        .exit_grant (exit_grant),
        .gate_open  (gate_open),
        .occupancy  (occupancy),
        .lot_full   (lot_full),
        .lot_empty  (lot_empty),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit dir;          // 0 = entry, 1 = exit
        int occ_before;
        int open_len;
        bit timeout;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_grants = 0;
    int   n_timeouts = 0;
    int   m_occ = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per grant and tracks how long the gate then stays open.
    initial begin
        bit active = 1'b0;
        bit prev_grant = 1'b0;
        bit prev_tmo = 1'b0;
        int open_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active     = 1'b0;
                prev_grant = 1'b0;
                prev_tmo   = 1'b0;
            end else begin
                if (entry_grant || exit_grant) begin
                    n_grants++;
                    check("grant_onehot", entry_grant & exit_grant, 0);
                    check("grant_is_pulse", prev_grant, 0);
                    check("sb_pending", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        cur = sb.pop_front();
                        check("grant_dir", exit_grant, cur.dir);
                        check("grant_occ", occupancy, cur.occ_before);
                        active   = 1'b1;
                        open_cnt = 0;
                    end
                end
                if (timeout_err) begin
                    n_timeouts++;
                    check("timeout_is_pulse", prev_tmo, 0);
                    check("timeout_expected", cur.timeout, 1);
                end
                if (active) begin
                    if (gate_open) begin
                        open_cnt++;
                    end else begin
                        check("open_len", open_cnt, cur.open_len);
                        active = 1'b0;
                    end
                end
                prev_grant = entry_grant | exit_grant;
                prev_tmo   = timeout_err;
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        entry_req  = 1'b0;
        exit_req   = 1'b0;
        car_passed = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_occ = 0;
    endtask

    task automatic wait_grant(output int ticks);
        bit seen = 1'b0;
        ticks = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            ticks++;
            if (entry_grant || exit_grant) seen = 1'b1;
        end
        check("grant_seen", seen, 1);
    endtask

    // Called one cycle-step after the edge that moved the FSM into CLOSING.
    task automatic wait_closed();
        tick();
        check("busy_closing", busy, 1);
        tick();
        check("busy_idle", busy, 0);
    endtask

    // delay > 0: car_passed sampled delay edges after the grant edge; delay == 0: let it time out.
    task automatic serve(input bit dir, input int delay);
        exp_t e;
        int   t;
        e.dir        = dir;
        e.occ_before = m_occ;
        e.open_len   = (delay > 0) ? delay : OPEN_TIMEOUT;
        e.timeout    = (delay == 0);
        sb.push_back(e);
        if (dir) exit_req = 1'b1;
        else     entry_req = 1'b1;
        wait_grant(t);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        check("gate_open_on_grant", gate_open, 1);
        if (delay > 0) begin
            repeat (delay - 1) tick();
            car_passed = 1'b1;
            tick();
            car_passed = 1'b0;
            m_occ += dir ? -1 : 1;
        end else begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                tick();
                if (timeout_err) seen = 1'b1;
            end
            check("timeout_seen", seen, 1);
        end
        wait_closed();
        check("occupancy", occupancy, m_occ);
    endtask

    initial begin
        int t;
        int g0;
        exp_t e;

        // 1: reset state, then one entry with car_passed 3 cycles after the grant
        do_reset();
        check("rst_occ", occupancy, 0);
        check("rst_gate", gate_open, 0);
        check("rst_busy", busy, 0);
        check("rst_grants", {entry_grant, exit_grant, timeout_err}, 0);
        check("rst_empty", lot_empty, 1);
        check("rst_full", lot_full, 0);
        serve(1'b0, 3);
        check("t1_occ", occupancy, 1);

        // 2: build occ=2 with last served = exit, then alternate on held tie
        do_reset();
        repeat (3) serve(1'b0, 1);
        serve(1'b1, 1);
        check("t2_occ_start", occupancy, 2);
        for (int k = 0; k < 4; k++) begin
            e.dir        = k[0];
            e.occ_before = k[0] ? 3 : 2;
            e.open_len   = 1;
            e.timeout    = 1'b0;
            sb.push_back(e);
        end
        entry_req = 1'b1;
        exit_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(t);
            check("tie_dir", exit_grant, k[0]);
            if (k > 0) check("grant_spacing", t, CLOSE_CYCLES + 1);
            if (k == 3) begin
                entry_req = 1'b0;
                exit_req  = 1'b0;
            end
            car_passed = 1'b1;
            tick();
            car_passed = 1'b0;
            m_occ += k[0] ? -1 : 1;
        end
        wait_closed();
        check("t2_occ_end", occupancy, 2);

        // 3: fill to capacity; entry blocked until an exit frees a space
        repeat (CAPACITY - 2) serve(1'b0, 2);
        check("t3_full", lot_full, 1);
        check("t3_occ", occupancy, CAPACITY);
        g0 = n_grants;
        entry_req = 1'b1;
        repeat (10) tick();
        check("t3_no_grant", n_grants, g0);
        check("t3_idle", busy, 0);
        e.dir = 1'b1; e.occ_before = CAPACITY;     e.open_len = 2; e.timeout = 1'b0;
        sb.push_back(e);
        e.dir = 1'b0; e.occ_before = CAPACITY - 1; e.open_len = 2; e.timeout = 1'b0;
        sb.push_back(e);
        exit_req = 1'b1;
        wait_grant(t);
        exit_req = 1'b0;
        check("t3_exit_first", exit_grant, 1);
        tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        m_occ = CAPACITY - 1;
        wait_closed();
        check("t3_occ_after_exit", occupancy, CAPACITY - 1);
        check("t3_not_full", lot_full, 0);
        wait_grant(t);
        entry_req = 1'b0;
        check("t3_pending_entry", entry_grant, 1);
        tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        m_occ = CAPACITY;
        wait_closed();
        check("t3_refull", lot_full, 1);

        // 4: entry with no car -> timeout after exactly OPEN_TIMEOUT open cycles
        do_reset();
        serve(1'b0, 0);
        check("t4_timeouts", n_timeouts, 1);
        check("t4_occ", occupancy, 0);

        // 5: exit on an empty lot never granted; stray car_passed ignored
        g0 = n_grants;
        exit_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_busy", busy, 0);
        end
        check("t5_no_grant", n_grants, g0);
        exit_req   = 1'b0;
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        tick();
        check("t5_occ", occupancy, 0);
        check("t5_empty", lot_empty, 1);

        // 6: reset while in WAIT_OUT with occupancy 5
        repeat (5) serve(1'b0, 1);
        check("t6_occ5", occupancy, 5);
        e.dir = 1'b1; e.occ_before = 5; e.open_len = 0; e.timeout = 1'b0;
        sb.push_back(e);
        exit_req = 1'b1;
        wait_grant(t);
        exit_req = 1'b0;
        check("t6_exit_grant", exit_grant, 1);
        tick();
        check("t6_still_open", gate_open, 1);
        reset = 1'b1;
        tick();
        check("t6_gate", gate_open, 0);
        check("t6_occ", occupancy, 0);
        check("t6_busy", busy, 0);
        check("t6_empty", lot_empty, 1);
        reset = 1'b0;
        m_occ = 0;
        tick();

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
